data_pipe_1ton_pkt: RTL and testbench

//  Packet-aware 1:N width up-converter with a built-in output FIFO. Packs NSIZE beats of DSIZE into one

---
 rtl/data_pipe_1ton_pkt.sv | 147 ++++++++++++++
 tb/tb_data_pipe_1ton_pkt.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_pipe_1ton_pkt.sv
// Packet-aware 1:N width up-converter: packs NSIZE narrow beats into one wide word,
// flushes partial words on wr_last with a lane-keep mask, and buffers words in a FWFT FIFO.

module data_pipe_1ton_pkt_lane #(
  parameter int               DSIZE     = 8,
  parameter logic [DSIZE-1:0] PAD_VALUE = '0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_hit,
  input  logic             i_flush,
  input  logic [DSIZE-1:0] i_data,
  output logic [DSIZE-1:0] o_data,
  output logic             o_keep
);
  logic [DSIZE-1:0] r_val;
  logic             r_kept;

  // Lane view of the word being completed this cycle, including the beat landing now.
  assign o_data = i_hit ? i_data : r_val;
  assign o_keep = i_hit | r_kept;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_val  <= PAD_VALUE;
      r_kept <= 1'b0;
    end else if (i_flush) begin
      r_val  <= PAD_VALUE;
      r_kept <= 1'b0;
    end else if (i_hit) begin
      r_val  <= i_data;
      r_kept <= 1'b1;
    end
  end
endmodule

module data_pipe_1ton_pkt #(
  parameter int               DSIZE     = 8,
  parameter int               NSIZE     = 4,
  parameter int               DEPTH     = 4,
  parameter int               MSB_FIRST = 0,
  parameter logic [DSIZE-1:0] PAD_VALUE = '0
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic [DSIZE-1:0]             wr_data,
  input  logic                         wr_vld,
  output logic                         wr_ready,
  input  logic                         wr_last,
  output logic [DSIZE*NSIZE-1:0]       rd_data,
  output logic [NSIZE-1:0]             rd_keep,
  output logic                         rd_last,
  output logic                         rd_vld,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
  localparam int LW = $clog2(NSIZE);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [NSIZE-1:0][DSIZE-1:0] data;
    logic [NSIZE-1:0]            keep;
    logic                        last;
  } word_t;

  logic [LW-1:0]               r_lc;
  logic [AW-1:0]               r_wptr, r_rptr;
  logic [CW-1:0]               r_cnt;
  logic                        r_wr_ready;
  word_t                       r_mem [DEPTH];

  logic                        w_accept, w_end, w_push, w_pop;
  logic [LW-1:0]               w_lane;
  logic [NSIZE-1:0]            w_hit, w_keep;
  logic [NSIZE-1:0][DSIZE-1:0] w_data;
  logic [CW-1:0]               w_cnt_nxt;
  word_t                       w_word, w_head;

  assign w_accept = wr_vld & r_wr_ready;
  assign w_end    = (r_lc == LW'(NSIZE-1)) | wr_last;
  assign w_push   = w_accept & w_end;
  assign w_pop    = rd_vld & rd_ready;
  assign w_lane   = (MSB_FIRST != 0) ? (LW'(NSIZE-1) - r_lc) : r_lc;

  for (genvar g = 0; g < NSIZE; g++) begin : g_lane
    assign w_hit[g] = w_accept & (w_lane == LW'(g));
    data_pipe_1ton_pkt_lane #(
      .DSIZE     (DSIZE),
      .PAD_VALUE (PAD_VALUE)
    ) u_lane (
      .clock   (clock),
      .rst_n   (rst_n),
      .i_hit   (w_hit[g]),
      .i_flush (w_push),
      .i_data  (wr_data),
      .o_data  (w_data[g]),
      .o_keep  (w_keep[g])
    );
  end

  always_comb begin
    w_word      = '0;
    w_word.data = w_data;
    w_word.keep = w_keep;
    w_word.last = wr_last;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)        r_lc <= '0;
    else if (w_accept) r_lc <= w_end ? '0 : r_lc + LW'(1);
  end

  // Storage is not reset; the read side is gated by rd_vld so stale entries never leak.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + CW'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - CW'(1);
  end

  // wr_ready comes straight from a flop so nothing on the read side or wr_last reaches it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt      <= w_cnt_nxt;
      r_wr_ready <= (w_cnt_nxt < CW'(DEPTH));
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign rd_vld     = (r_cnt != '0);
  assign rd_data    = rd_vld ? w_head.data : '0;
  assign rd_keep    = rd_vld ? w_head.keep : '0;
  assign rd_last    = rd_vld & w_head.last;
  assign wr_ready   = r_wr_ready;
  assign fifo_count = r_cnt;
endmodule

// File: tb/tb_data_pipe_1ton_pkt.sv
// Directed + randomized checks of the 1:N packer/FIFO, LSB-first and MSB-first instances fed in parallel.

module tb_data_pipe_1ton_pkt;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_vld = 1'b0, wr_last = 1'b0, rd_ready = 1'b0;

  logic        wr_ready, rd_vld, rd_last;
  logic [31:0] rd_data;
  logic [3:0]  rd_keep;
  logic [2:0]  fifo_count;
  logic        m_wr_ready, m_rd_vld, m_rd_last;
  logic [31:0] m_rd_data;
  logic [3:0]  m_rd_keep;
  logic [2:0]  m_fifo_count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } exp_t;
  exp_t exp_q[$];
  logic drv_done = 1'b0;

  always #5 clock = ~clock;

  data_pipe_1ton_pkt #(.DSIZE(8), .NSIZE(4), .DEPTH(4), .MSB_FIRST(0)) u_dut (
    .clock(clock), .rst_n(rst_n), .wr_data(wr_data), .wr_vld(wr_vld), .wr_ready(wr_ready),
    .wr_last(wr_last), .rd_data(rd_data), .rd_keep(rd_keep), .rd_last(rd_last),
    .rd_vld(rd_vld), .rd_ready(rd_ready), .fifo_count(fifo_count));

  data_pipe_1ton_pkt #(.DSIZE(8), .NSIZE(4), .DEPTH(4), .MSB_FIRST(1)) u_dut_msb (
    .clock(clock), .rst_n(rst_n), .wr_data(wr_data), .wr_vld(wr_vld), .wr_ready(m_wr_ready),
    .wr_last(wr_last), .rd_data(m_rd_data), .rd_keep(m_rd_keep), .rd_last(m_rd_last),
    .rd_vld(m_rd_vld), .rd_ready(rd_ready), .fifo_count(m_fifo_count));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    wr_data = d;
    wr_last = l;
    wr_vld  = 1'b1;
    while (!wr_ready && n < 200) begin
      tick();
      n++;
    end
    if (!wr_ready) chk("send_timeout", wr_ready, 1);
    tick();
    wr_vld  = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    chk({tag, "_vld"},  rd_vld,  1);
    chk({tag, "_data"}, rd_data, d);
    chk({tag, "_keep"}, rd_keep, k);
    chk({tag, "_last"}, rd_last, l);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  localparam logic [31:0] T3W [4] = '{32'h04030201, 32'h08070605, 32'h0c0b0a09, 32'h100f0e0d};
  localparam logic [31:0] T4W [4] = '{32'h33323130, 32'h37363534, 32'h3b3a3938, 32'h3f3e3d3c};

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_vld",   rd_vld,   0);
    chk("rst_rd_data",  rd_data,  0);
    chk("rst_rd_keep",  rd_keep,  0);
    chk("rst_rd_last",  rd_last,  0);
    chk("rst_count",    fifo_count, 0);
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("rdy_after_rst", wr_ready, 1);

    // T1: full word, both lane orders
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    chk("t1_count", fifo_count, 1);
    chk("t1_msb_data", m_rd_data, 32'h11223344);
    chk("t1_msb_keep", m_rd_keep, 4'hF);
    pop_chk("t1", 32'h44332211, 4'hF, 1);
    chk("t1_empty_vld", rd_vld, 0);
    chk("t1_empty_cnt", fifo_count, 0);

    // T2: partial word flushed by wr_last
    send(8'hAA, 0); send(8'hBB, 1);
    chk("t2_msb_data", m_rd_data, 32'hAABB0000);
    chk("t2_msb_keep", m_rd_keep, 4'b1100);
    chk("t2_msb_last", m_rd_last, 1);
    pop_chk("t2", 32'h0000BBAA, 4'b0011, 1);

    // T2b: single-beat packet
    send(8'h5A, 1);
    chk("t2b_msb_keep", m_rd_keep, 4'b1000);
    pop_chk("t2b", 32'h0000005A, 4'b0001, 1);

    // T3: fill with consumer stalled, held beat, drain, resume
    for (int i = 1; i <= 16; i++) send(8'(i), 0);
    chk("t3_count_full", fifo_count, 4);
    chk("t3_ready_full", wr_ready, 0);
    chk("t3_msb_ready_full", m_wr_ready, 0);
    wr_data = 8'd17; wr_vld = 1'b1;
    tick(); tick(); tick();
    chk("t3_held_count", fifo_count, 4);
    chk("t3_held_ready", wr_ready, 0);
    chk("t3_stall_data", rd_data, 32'h04030201);
    wr_vld = 1'b0;
    chk("t3_msb_head", m_rd_data, 32'h01020304);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("t3_w%0d", k), T3W[k], 4'hF, 0);
    for (int i = 17; i <= 20; i++) send(8'(i), i == 20);
    pop_chk("t3_w4", 32'h14131211, 4'hF, 1);

    // T4: full FIFO, push and pop offered together -> pop only
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 0);
    chk("t4_count_full", fifo_count, 4);
    wr_data = 8'hEE; wr_vld = 1'b1; rd_ready = 1'b1;
    tick();
    wr_vld = 1'b0; rd_ready = 1'b0;
    chk("t4_count", fifo_count, 3);
    chk("t4_ready", wr_ready, 1);
    for (int k = 1; k < 4; k++) pop_chk($sformatf("t4_w%0d", k), T4W[k], 4'hF, 0);
    chk("t4_count_empty", fifo_count, 0);

    // T5: random traffic against a packing model
    fork
      begin : drv
        logic [3:0][7:0] mw;
        logic [3:0]      mk;
        int              mlc, len, n;
        logic [7:0]      d;
        logic            l;
        mw = '0; mk = '0; mlc = 0;
        for (int p = 0; p < 40; p++) begin
          len = $urandom_range(1, 13);
          for (int b = 0; b < len; b++) begin
            wr_vld = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            d = 8'($urandom);
            l = (b == len - 1);
            wr_data = d; wr_last = l; wr_vld = 1'b1;
            n = 0;
            while (!wr_ready && n < 500) begin tick(); n++; end
            if (!wr_ready) chk("t5_drv_timeout", wr_ready, 1);
            mw[mlc] = d;
            mk[mlc] = 1'b1;
            if (mlc == 3 || l) begin
              exp_q.push_back('{d: mw, k: mk, l: l});
              mw = '0; mk = '0; mlc = 0;
            end else mlc++;
            tick();
          end
        end
        wr_vld = 1'b0; wr_last = 1'b0;
        drv_done = 1'b1;
      end
      begin : mon
        exp_t        e;
        logic        prev_stall;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        int          cyc;
        prev_stall = 1'b0; pd = '0; pk = '0; pl = 1'b0; cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 20000) begin
          rd_ready = ($urandom_range(0, 3) != 0);
          if (prev_stall) begin
            chk("t5_stall_vld",  rd_vld,  1);
            chk("t5_stall_data", rd_data, pd);
            chk("t5_stall_keep", rd_keep, pk);
            chk("t5_stall_last", rd_last, pl);
          end
          if (rd_vld && rd_ready) begin
            if (exp_q.size() == 0) chk("t5_extra_word", exp_q.size(), 1);
            else begin
              e = exp_q.pop_front();
              chk("t5_data", rd_data, e.d);
              chk("t5_keep", rd_keep, e.k);
              chk("t5_last", rd_last, e.l);
            end
          end
          prev_stall = rd_vld && !rd_ready;
          pd = rd_data; pk = rd_keep; pl = rd_last;
          tick();
          cyc++;
        end
        rd_ready = 1'b0;
        chk("t5_leftover", exp_q.size(), 0);
      end
    join
    tick();
    chk("t5_count_end", fifo_count, 0);

    // T6: reset mid-packet with stored words
    for (int i = 0; i < 10; i++) send(8'h80 + 8'(i), 0);
    chk("t6_count_pre", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",   rd_vld,     0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_data",  rd_data,    0);
    chk("t6_rst_ready", wr_ready,   0);
    tick();
    #2 rst_n = 1'b1;
    tick(); tick();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    chk("t6_count", fifo_count, 1);
    chk("t6_msb_data", m_rd_data, 32'h01020304);
    pop_chk("t6", 32'h04030201, 4'hF, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
